// File: rtl/store_commit_buffer.sv
// Post-commit store queue: buffers retired stores and drains them in order to
// data memory, one outstanding write at a time; flags loads hitting a buffered word.

module scb_word_match #(
  parameter int ADDR_W = 64
) (
  input  logic              entry_vld,
  input  logic [ADDR_W-1:0] entry_addr,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit
);
  // Same 8-byte word: everything above bit 2 matches.
  assign hit = entry_vld && (((entry_addr ^ ld_addr) >> 3) == '0);
endmodule

module store_commit_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_commit_valid,
  input  logic [ADDR_W-1:0] in_commit_addr,
  input  logic [DATA_W-1:0] in_commit_data,
  output logic              out_commit_ready,
  output logic              out_mem_req_valid,
  output logic [ADDR_W-1:0] out_mem_req_addr,
  output logic [DATA_W-1:0] out_mem_req_data,
  input  logic              in_mem_req_ready,
  input  logic              in_mem_ack,
  input  logic [ADDR_W-1:0] in_ld_addr,
  output logic              out_ld_conflict,
  output logic [CNT_W-1:0]  out_pending_count,
  output logic              out_full,
  output logic              out_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t                      state_q;
  entry_t                      ent_q [DEPTH];
  logic [DEPTH-1:0]            vld_q;
  logic [PTR_W-1:0]            head_q, tail_q;
  logic [CNT_W-1:0]            count_q, count_n;
  logic                        full_q, empty_q, req_vld_q;
  logic                        push, pop;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0]            hit;

  assign out_commit_ready = (count_q < CNT_W'(DEPTH));
  // Ready comes from the registered count, so a same-cycle pop never frees a slot.
  assign push    = in_commit_valid && out_commit_ready;
  assign pop     = (state_q == WAIT) && in_mem_ack;
  assign count_n = count_q + CNT_W'(push) - CNT_W'(pop);

  assign out_mem_req_valid = req_vld_q;
  assign out_mem_req_addr  = ent_q[head_q].addr;
  assign out_mem_req_data  = ent_q[head_q].data;
  assign out_pending_count = count_q;
  assign out_full          = full_q;
  assign out_empty         = empty_q;

  always_ff @(posedge in_clk) begin
    if (push) ent_q[tail_q] <= '{addr: in_commit_addr, data: in_commit_data};
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= IDLE;
      vld_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      req_vld_q <= 1'b0;
    end else begin
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      count_q <= count_n;
      full_q  <= (count_n == CNT_W'(DEPTH));
      empty_q <= (count_n == '0);
      case (state_q)
        IDLE: if (count_n != '0) begin
          state_q   <= REQ;
          req_vld_q <= 1'b1;
        end
        REQ: if (in_mem_req_ready) begin
          state_q   <= WAIT;
          req_vld_q <= 1'b0;
        end
        WAIT: if (in_mem_ack) begin
          state_q   <= (count_n != '0) ? REQ : IDLE;
          req_vld_q <= (count_n != '0);
        end
        default: begin
          state_q   <= IDLE;
          req_vld_q <= 1'b0;
        end
      endcase
    end
  end

  // The in-flight entry stays valid until its ack, so it keeps blocking loads.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign ent_addr[g] = ent_q[g].addr;
    scb_word_match #(.ADDR_W(ADDR_W)) u_cmp (
      .entry_vld (vld_q[g]),
      .entry_addr(ent_addr[g]),
      .ld_addr   (in_ld_addr),
      .hit       (hit[g])
    );
  end

  assign out_ld_conflict = |hit;
endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: in-order drain, full/backpressure,
// wrap, push+pop, load conflict and async reset mid-drain.

module tb_store_commit_buffer;
  localparam int DEPTH = 4, ADDR_W = 64, DATA_W = 64, CNT_W = 3;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              commit_valid = 1'b0;
  logic [ADDR_W-1:0] commit_addr = '0, ld_addr = '0;
  logic [DATA_W-1:0] commit_data = '0;
  logic              commit_ready, req_valid, req_ready = 1'b0, mem_ack = 1'b0;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              ld_conflict, full, empty;
  logic [CNT_W-1:0]  count;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_commit_valid(commit_valid), .in_commit_addr(commit_addr), .in_commit_data(commit_data),
    .out_commit_ready(commit_ready),
    .out_mem_req_valid(req_valid), .out_mem_req_addr(req_addr), .out_mem_req_data(req_data),
    .in_mem_req_ready(req_ready), .in_mem_ack(mem_ack),
    .in_ld_addr(ld_addr), .out_ld_conflict(ld_conflict),
    .out_pending_count(count), .out_full(full), .out_empty(empty)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d);
    commit_valid = 1'b1; commit_addr = a; commit_data = d;
    tick();
    commit_valid = 1'b0;
  endtask

  // Wait for a request, check it, handshake, ack on the following cycle.
  task automatic drain_one(input string tag, input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 20 && !req_valid; i++) tick();
    chk({tag, "_req_seen"}, req_valid, 1'b1);
    chk({tag, "_addr"}, req_addr, a);
    chk({tag, "_data"}, req_data, d);
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    chk({tag, "_wait_novalid"}, req_valid, 1'b0);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ready"}, commit_ready, 1);
    chk({tag, "_req_valid"}, req_valid, 0);
    chk({tag, "_conflict"}, ld_conflict, 0);
  endtask

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outs("rst");

    // 1: single store, ack two cycles after the handshake
    push(64'h100, 64'h11);
    chk("t1_count", count, 1);
    chk("t1_req_valid", req_valid, 1);
    chk("t1_addr", req_addr, 64'h100);
    chk("t1_data", req_data, 64'h11);
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    chk("t1_wait_valid", req_valid, 0);
    chk("t1_wait_count", count, 1);
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("t1_done_count", count, 0);
    chk("t1_done_empty", empty, 1);
    tick();
    chk("t1_idle_valid", req_valid, 0);

    // 2: fill with memory stalled; fifth push rejected
    for (int i = 0; i < 4; i++) push(64'h200 + 64'(i) * 16, 64'hA0 + 64'(i));
    chk("t2_count", count, 4);
    chk("t2_full", full, 1);
    chk("t2_ready", commit_ready, 0);
    chk("t2_addr_stable", req_addr, 64'h200);
    push(64'h240, 64'hFF);
    chk("t2_reject_count", count, 4);
    chk("t2_stable_addr", req_addr, 64'h200);
    chk("t2_stable_data", req_data, 64'hA0);
    chk("t2_stable_valid", req_valid, 1);
    for (int i = 0; i < 4; i++) drain_one("t2_drain", 64'h200 + 64'(i) * 16, 64'hA0 + 64'(i));
    chk("t2_final_count", count, 0);
    chk("t2_final_empty", empty, 1);

    // 3: six stores interleaved with drains, pointers wrap
    for (int i = 1; i <= 4; i++) push(64'(i) * 16, 64'(i));
    drain_one("t3_d10", 64'h10, 64'h1);
    push(64'h50, 64'h5);
    drain_one("t3_d20", 64'h20, 64'h2);
    push(64'h60, 64'h6);
    chk("t3_mid_count", count, 4);
    drain_one("t3_d30", 64'h30, 64'h3);
    drain_one("t3_d40", 64'h40, 64'h4);
    drain_one("t3_d50", 64'h50, 64'h5);
    drain_one("t3_d60", 64'h60, 64'h6);
    chk("t3_final_count", count, 0);

    // 4: push and ack in the same cycle at count 2
    push(64'h300, 64'h30);
    push(64'h310, 64'h31);
    chk("t4_count2", count, 2);
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    mem_ack = 1'b1; commit_valid = 1'b1; commit_addr = 64'h320; commit_data = 64'h32;
    tick();
    mem_ack = 1'b0; commit_valid = 1'b0;
    chk("t4_count_same", count, 2);
    chk("t4_next_valid", req_valid, 1);
    chk("t4_next_addr", req_addr, 64'h310);
    drain_one("t4_d310", 64'h310, 64'h31);
    drain_one("t4_d320", 64'h320, 64'h32);
    chk("t4_empty", empty, 1);

    // 5: load conflict on the same 8-byte word, held through the in-flight write
    push(64'h208, 64'h55);
    ld_addr = 64'h20C; #1; chk("t5_hit_20c", ld_conflict, 1);
    ld_addr = 64'h210; #1; chk("t5_miss_210", ld_conflict, 0);
    ld_addr = 64'h200; #1; chk("t5_miss_200", ld_conflict, 0);
    for (int i = 0; i < 20 && !req_valid; i++) tick();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    ld_addr = 64'h20C; #1; chk("t5_inflight_hit", ld_conflict, 1);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("t5_after_ack_20c", ld_conflict, 0);
    ld_addr = 64'h210; #1; chk("t5_after_ack_210", ld_conflict, 0);

    // 6: async reset while waiting for an ack with three stores buffered
    push(64'h400, 64'h40);
    push(64'h410, 64'h41);
    push(64'h420, 64'h42);
    for (int i = 0; i < 20 && !req_valid; i++) tick();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    chk("t6_pre_count", count, 3);
    ld_addr = 64'h400; #1; chk("t6_pre_conflict", ld_conflict, 1);
    rst_n = 1'b0; #1;
    chk_reset_outs("t6_rst");
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("t6_late_ack_count", count, 0);
    chk("t6_late_ack_valid", req_valid, 0);
    push(64'h500, 64'h50);
    chk("t6_post_count", count, 1);
    chk("t6_post_addr", req_addr, 64'h500);
    drain_one("t6_d500", 64'h500, 64'h50);
    chk("t6_post_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
